// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters (CPU MEM stage, debug loader),
// the arbiter and d_memory. DMEM_ARB_ALIGN_CHECK_EN adds the per-port error flags.
interface dmem_arbiter_if #(
    parameter int unsigned WORDLENGTH = 32
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [WORDLENGTH-1:0] cpu_addr;
    logic [WORDLENGTH-1:0] cpu_wdata;
    logic                  cpu_gnt;
    logic                  cpu_rvalid;
    logic [WORDLENGTH-1:0] cpu_rdata;
    logic                  cpu_stall;

    logic                  dbg_req;
    logic                  dbg_we;
    logic [WORDLENGTH-1:0] dbg_addr;
    logic [WORDLENGTH-1:0] dbg_wdata;
    logic                  dbg_lock;
    logic                  dbg_gnt;
    logic                  dbg_rvalid;
    logic [WORDLENGTH-1:0] dbg_rdata;

    logic [WORDLENGTH-1:0] mem_addr;
    logic [WORDLENGTH-1:0] mem_wdata;
    logic                  mem_read_en;
    logic                  mem_write_en;
    logic [WORDLENGTH-1:0] mem_rdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    logic                  cpu_err;
    logic                  dbg_err;
`endif

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        input  mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_addr, mem_wdata, mem_read_en, mem_write_en
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        ,
        output cpu_err, dbg_err
`endif
    );

    // Requester / memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
        output mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, cpu_stall,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_addr, mem_wdata, mem_read_en, mem_write_en
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        ,
        input  cpu_err, dbg_err
`endif
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU priority, starvation-bounded DBG access, DBG burst lock.
// Optional misaligned-access trapping under DMEM_ARB_ALIGN_CHECK_EN.
module dmem_arbiter #(
    parameter int unsigned WORDLENGTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [0:0] {
        ARB      = 1'b0,
        DBG_LOCK = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic                  cpu_rvalid_q, cpu_rvalid_d;
    logic                  dbg_rvalid_q, dbg_rvalid_d;
    logic [WORDLENGTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [WORDLENGTH-1:0] dbg_rdata_q, dbg_rdata_d;
    logic                  cpu_err_q, cpu_err_d;
    logic                  dbg_err_q, dbg_err_d;

    logic                  cpu_gnt_c, dbg_gnt_c;
    logic                  sel_we_c, misalign_c, rd_c, wr_c;
    logic [WORDLENGTH-1:0] sel_addr_c, sel_wdata_c;

    // Grant, FSM next state and starvation counter; no grant while reset is held
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        cpu_gnt_c = 1'b0;
        dbg_gnt_c = 1'b0;
        if (reset) begin
            unique case (state_q)
                ARB: begin
                    if (bus.dbg_req && (starve_q == CNT_W'(STARVE_LIMIT))) dbg_gnt_c = 1'b1;
                    else if (bus.cpu_req)                                  cpu_gnt_c = 1'b1;
                    else if (bus.dbg_req)                                  dbg_gnt_c = 1'b1;
                    if (dbg_gnt_c && bus.dbg_lock) state_d = DBG_LOCK;
                end
                DBG_LOCK: begin
                    dbg_gnt_c = bus.dbg_req;
                    if (!bus.dbg_lock || !bus.dbg_req) state_d = ARB;
                end
                default: state_d = ARB;
            endcase
        end
        if (!bus.dbg_req || dbg_gnt_c) begin
            starve_d = '0;
        end else if (cpu_gnt_c && (starve_q != CNT_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // Memory command mux and read-return capture
    always_comb begin
        sel_we_c    = 1'b0;
        sel_addr_c  = '0;
        sel_wdata_c = '0;
        if (cpu_gnt_c) begin
            sel_we_c    = bus.cpu_we;
            sel_addr_c  = bus.cpu_addr;
            sel_wdata_c = bus.cpu_wdata;
        end else if (dbg_gnt_c) begin
            sel_we_c    = bus.dbg_we;
            sel_addr_c  = bus.dbg_addr;
            sel_wdata_c = bus.dbg_wdata;
        end
`ifdef DMEM_ARB_ALIGN_CHECK_EN
        misalign_c = (cpu_gnt_c || dbg_gnt_c) && (sel_addr_c[1:0] != 2'b00);
`else
        misalign_c = 1'b0;
`endif
        rd_c = (cpu_gnt_c || dbg_gnt_c) && !sel_we_c && !misalign_c;
        wr_c = (cpu_gnt_c || dbg_gnt_c) &&  sel_we_c && !misalign_c;

        cpu_rvalid_d = cpu_gnt_c && rd_c;
        dbg_rvalid_d = dbg_gnt_c && rd_c;
        cpu_rdata_d  = cpu_rvalid_d ? bus.mem_rdata : cpu_rdata_q;
        dbg_rdata_d  = dbg_rvalid_d ? bus.mem_rdata : dbg_rdata_q;
        cpu_err_d    = cpu_gnt_c && misalign_c;
        dbg_err_d    = dbg_gnt_c && misalign_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB;
            starve_q     <= '0;
            cpu_rvalid_q <= 1'b0;
            dbg_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
            cpu_err_q    <= 1'b0;
            dbg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
            cpu_err_q    <= cpu_err_d;
            dbg_err_q    <= dbg_err_d;
        end
    end

    assign bus.cpu_gnt      = cpu_gnt_c;
    assign bus.dbg_gnt      = dbg_gnt_c;
    assign bus.cpu_stall    = bus.cpu_req && !cpu_gnt_c;
    assign bus.cpu_rvalid   = cpu_rvalid_q;
    assign bus.dbg_rvalid   = dbg_rvalid_q;
    assign bus.cpu_rdata    = cpu_rdata_q;
    assign bus.dbg_rdata    = dbg_rdata_q;
    assign bus.mem_addr     = sel_addr_c;
    assign bus.mem_wdata    = sel_wdata_c;
    assign bus.mem_read_en  = rd_c;
    assign bus.mem_write_en = wr_c;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
    assign bus.cpu_err = cpu_err_q;
    assign bus.dbg_err = dbg_err_q;
`else
    logic unused_err_c;
    assign unused_err_c = cpu_err_q ^ dbg_err_q;
`endif
endmodule
